// File: rtl/acc_arbiter_ctrl_pkg.sv
// Shared types and constants for the accumulate-job arbiter/sequencer.
//   - state_e   : sequencing FSM states
//   - dp_beat_t : one operand beat as presented to the add/accumulate datapath
//   - DP_BUBBLE : the all-zero beat (adds 0 to the accumulator)
package acc_arbiter_ctrl_pkg;

  localparam int DP_SEL_W = 2;
  localparam int DP_OP_W  = 3;
  localparam int ACC_W    = 6;
  localparam int NUM_REQ  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
    ST_DRAIN,
    ST_RESP
  } state_e;

  typedef struct packed {
    logic [DP_OP_W-1:0]  data1;
    logic [DP_OP_W-1:0]  data2;
    logic [DP_SEL_W-1:0] sel;
  } dp_beat_t;

  localparam logic [DP_OP_W-1:0]  DP_ZERO_OP    = '0;
  localparam logic [DP_SEL_W-1:0] DP_SEL_BUBBLE = '0;
  localparam dp_beat_t DP_BUBBLE = '{data1: DP_ZERO_OP, data2: DP_ZERO_OP, sel: DP_SEL_BUBBLE};

endpackage

// File: rtl/acc_arbiter_ctrl_rr_arb2.sv
// Two-way round-robin picker.
//   i_req       : request bits, bit r = requester r
//   i_done      : job-complete strobe; moves the pointer away from i_done_id
//   i_done_id   : requester whose job just completed
//   o_grant_id  : combinational pick (meaningful when any i_req bit is set)
// The pointer names the preferred requester; the other one wins only when
// the preferred one is idle.
module rr_arb2 (
  input  logic       clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  input  logic       i_done,
  input  logic       i_done_id,
  output logic       o_grant_id
);

  logic ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (i_done) ptr_d = ~i_done_id;
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) ptr_q <= 1'b0;
    else          ptr_q <= ptr_d;
  end

  assign o_grant_id = i_req[ptr_q] ? ptr_q : ~ptr_q;

endmodule

// File: rtl/acc_arbiter_ctrl.sv
// Sequencer and two-requester arbiter for the shared add/accumulate datapath.
// A job is a burst of beats ending in a 'last' beat (or force-ended at
// MAX_BEATS). Per job: grant, clear accumulator, stream beats, drain one
// cycle, return {id, sum, overflow, trunc} on the response channel.
// Ports:
//   clk, i_rst_n                  : clock, async active-low reset
//   i_req_valid/last[1:0]         : per-requester beat handshake
//   i_reqN_data1/data2/sel        : per-requester operands and select
//   o_req_ready[1:0]              : beat accept (granted requester, RUN only)
//   o_dp_data1/data2/sel/clear    : datapath drive
//   i_dp_data, i_dp_overflow      : accumulator value and overflow
//   o_rsp_*/i_rsp_ready           : response channel
//   o_busy                        : not IDLE
module acc_arbiter_ctrl
  import acc_arbiter_ctrl_pkg::*;
#(
  parameter int MAX_BEATS = 16,
  parameter int CNT_W     = 5
) (
  input  logic                clk,
  input  logic                i_rst_n,
  input  logic [1:0]          i_req_valid,
  input  logic [1:0]          i_req_last,
  input  logic [DP_OP_W-1:0]  i_req0_data1,
  input  logic [DP_OP_W-1:0]  i_req0_data2,
  input  logic [DP_OP_W-1:0]  i_req1_data1,
  input  logic [DP_OP_W-1:0]  i_req1_data2,
  input  logic [DP_SEL_W-1:0] i_req0_sel,
  input  logic [DP_SEL_W-1:0] i_req1_sel,
  output logic [1:0]          o_req_ready,
  output logic [DP_OP_W-1:0]  o_dp_data1,
  output logic [DP_OP_W-1:0]  o_dp_data2,
  output logic [DP_SEL_W-1:0] o_dp_sel,
  output logic                o_dp_clear,
  input  logic [ACC_W-1:0]    i_dp_data,
  input  logic                i_dp_overflow,
  output logic                o_rsp_valid,
  output logic                o_rsp_id,
  output logic [ACC_W-1:0]    o_rsp_data,
  output logic                o_rsp_overflow,
  output logic                o_rsp_trunc,
  input  logic                i_rsp_ready,
  output logic                o_busy
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e             state_q;
  logic               grant_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               ovf_q;
  logic               trunc_q;
  logic               rsp_valid_q, rsp_id_q, rsp_ovf_q, rsp_trunc_q;
  logic [ACC_W-1:0]   rsp_data_q;

  dp_beat_t [NUM_REQ-1:0] req_beat;
  dp_beat_t               dp_beat;
  logic [NUM_REQ-1:0]     ready;
  logic                   accept, beat_last, arb_grant, rsp_done;
  logic [CNT_W-1:0]       cnt_d;

  assign req_beat[0] = '{data1: i_req0_data1, data2: i_req0_data2, sel: i_req0_sel};
  assign req_beat[1] = '{data1: i_req1_data1, data2: i_req1_data2, sel: i_req1_sel};

  // Datapath is driven only in RUN; an idle granted requester becomes a
  // zero bubble so the accumulator holds its value.
  always_comb begin
    ready   = '0;
    dp_beat = DP_BUBBLE;
    if (state_q == ST_RUN) begin
      ready[grant_q] = 1'b1;
      if (i_req_valid[grant_q]) dp_beat = req_beat[grant_q];
    end
  end

  assign accept    = (state_q == ST_RUN) && i_req_valid[grant_q];
  assign beat_last = i_req_last[grant_q];
  assign cnt_d     = cnt_q + CNT_ONE;
  assign rsp_done  = (state_q == ST_RESP) && i_rsp_ready;

  rr_arb2 u_arb (
    .clk        (clk),
    .i_rst_n    (i_rst_n),
    .i_req      (i_req_valid),
    .i_done     (rsp_done),
    .i_done_id  (grant_q),
    .o_grant_id (arb_grant)
  );

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      grant_q     <= 1'b0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      trunc_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_ovf_q   <= 1'b0;
      rsp_trunc_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|i_req_valid) begin
            grant_q <= arb_grant;
            state_q <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          cnt_q   <= '0;
          ovf_q   <= 1'b0;
          trunc_q <= 1'b0;
          state_q <= ST_RUN;
        end
        ST_RUN: begin
          ovf_q <= ovf_q | i_dp_overflow;
          if (accept) begin
            cnt_q <= cnt_d;
            if (beat_last) begin
              state_q <= ST_DRAIN;
            end else if (cnt_d == MAX_CNT) begin
              // A last beat landing exactly on the limit is a normal end.
              trunc_q <= 1'b1;
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // The final beat reaches the accumulator register by now.
          ovf_q       <= ovf_q | i_dp_overflow;
          rsp_valid_q <= 1'b1;
          rsp_id_q    <= grant_q;
          rsp_data_q  <= i_dp_data;
          rsp_ovf_q   <= ovf_q | i_dp_overflow;
          rsp_trunc_q <= trunc_q;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          if (i_rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_req_ready    = ready;
  assign o_dp_data1     = dp_beat.data1;
  assign o_dp_data2     = dp_beat.data2;
  assign o_dp_sel       = dp_beat.sel;
  assign o_dp_clear     = (state_q == ST_CLEAR);
  assign o_rsp_valid    = rsp_valid_q;
  assign o_rsp_id       = rsp_id_q;
  assign o_rsp_data     = rsp_data_q;
  assign o_rsp_overflow = rsp_ovf_q;
  assign o_rsp_trunc    = rsp_trunc_q;
  assign o_busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_acc_arbiter_ctrl.sv
// Bench for acc_arbiter_ctrl: two instances (MAX_BEATS 16 and 4), each with
// its own accumulator model. Requester streams are beat queues; a stream
// model splits them into jobs and predicts every response.
module tb_acc_arbiter_ctrl;

  typedef struct { logic [2:0] d1; logic [2:0] d2; logic [1:0] sel; logic last; } beat_t;
  typedef struct { int id; int data; int ovf; int trunc; } rsp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [1:0] req_valid [2];
  logic [1:0] req_last  [2];
  logic [2:0] d1 [2][2];
  logic [2:0] d2 [2][2];
  logic [1:0] sel [2][2];
  logic       rsp_ready [2];

  logic [1:0] o_ready [2];
  logic [2:0] dp_d1 [2];
  logic [2:0] dp_d2 [2];
  logic [1:0] dp_sel [2];
  logic       dp_clr [2];
  logic [5:0] acc [2];
  logic       dovf [2];
  logic       rsp_v [2];
  logic       rsp_id [2];
  logic [5:0] rsp_data [2];
  logic       rsp_ovf [2];
  logic       rsp_tr [2];
  logic       busy [2];

  acc_arbiter_ctrl u_dut0 (
    .clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid[0]), .i_req_last(req_last[0]),
    .i_req0_data1(d1[0][0]), .i_req0_data2(d2[0][0]), .i_req1_data1(d1[0][1]), .i_req1_data2(d2[0][1]),
    .i_req0_sel(sel[0][0]), .i_req1_sel(sel[0][1]), .o_req_ready(o_ready[0]),
    .o_dp_data1(dp_d1[0]), .o_dp_data2(dp_d2[0]), .o_dp_sel(dp_sel[0]), .o_dp_clear(dp_clr[0]),
    .i_dp_data(acc[0]), .i_dp_overflow(dovf[0]), .o_rsp_valid(rsp_v[0]), .o_rsp_id(rsp_id[0]),
    .o_rsp_data(rsp_data[0]), .o_rsp_overflow(rsp_ovf[0]), .o_rsp_trunc(rsp_tr[0]),
    .i_rsp_ready(rsp_ready[0]), .o_busy(busy[0]));

  acc_arbiter_ctrl #(.MAX_BEATS(4), .CNT_W(3)) u_dut1 (
    .clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid[1]), .i_req_last(req_last[1]),
    .i_req0_data1(d1[1][0]), .i_req0_data2(d2[1][0]), .i_req1_data1(d1[1][1]), .i_req1_data2(d2[1][1]),
    .i_req0_sel(sel[1][0]), .i_req1_sel(sel[1][1]), .o_req_ready(o_ready[1]),
    .o_dp_data1(dp_d1[1]), .o_dp_data2(dp_d2[1]), .o_dp_sel(dp_sel[1]), .o_dp_clear(dp_clr[1]),
    .i_dp_data(acc[1]), .i_dp_overflow(dovf[1]), .o_rsp_valid(rsp_v[1]), .o_rsp_id(rsp_id[1]),
    .o_rsp_data(rsp_data[1]), .o_rsp_overflow(rsp_ovf[1]), .o_rsp_trunc(rsp_tr[1]),
    .i_rsp_ready(rsp_ready[1]), .o_busy(busy[1]));

  // Datapath select: 0 adds data1, 1 adds data2, 2 adds both, 3 adds nothing.
  function automatic int addend(logic [1:0] s, logic [2:0] a, logic [2:0] b);
    case (s)
      2'd0:    return int'(a);
      2'd1:    return int'(b);
      2'd2:    return int'(a) + int'(b);
      default: return 0;
    endcase
  endfunction

  // Accumulator with sticky carry-out, cleared by reset or clear pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int u = 0; u < 2; u++) begin acc[u] <= '0; dovf[u] <= 1'b0; end
    end else begin
      for (int u = 0; u < 2; u++) begin
        if (dp_clr[u]) begin
          acc[u]  <= '0;
          dovf[u] <= 1'b0;
        end else begin
          acc[u]  <= 6'(int'(acc[u]) + addend(dp_sel[u], dp_d1[u], dp_d2[u]));
          dovf[u] <= dovf[u] | ((int'(acc[u]) + addend(dp_sel[u], dp_d1[u], dp_d2[u])) > 63);
        end
      end
    end
  end

  // Stream k = u*2 + r.
  beat_t bq [4][$];
  rsp_t  eq [4][$];
  int    mcnt [4], msum [4], acc_cnt [4], bub_after [4], bub_len [4];
  int    lim [2] = '{16, 4};
  int    rsp_hold [2], nrsp [2], clr_cnt [2], first_rsp_cyc [2];
  int    ord [2][$];
  rsp_t  lastr [2];
  logic  prev_v [2];
  int    cyc, nvec, nerr;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Append a beat to a requester stream and advance the job model: a job
  // ends on 'last' or when its beat count hits the instance limit.
  task automatic push(int u, int r, logic [1:0] s, logic [2:0] a, logic [2:0] b, logic last);
    int k;
    beat_t bt;
    rsp_t e;
    k = u*2 + r;
    bt.d1 = a; bt.d2 = b; bt.sel = s; bt.last = last;
    bq[k].push_back(bt);
    mcnt[k]++;
    msum[k] += addend(s, a, b);
    if (last || mcnt[k] == lim[u]) begin
      e.id = r; e.data = msum[k] % 64; e.ovf = int'(msum[k] > 63); e.trunc = int'(!last);
      eq[k].push_back(e);
      mcnt[k] = 0;
      msum[k] = 0;
    end
  endtask

  task automatic reset_chk(int u, string tag);
    chk($sformatf("%s_u%0d_ready", tag, u), 32'(o_ready[u]), 0);
    chk($sformatf("%s_u%0d_dp", tag, u), {dp_d1[u], dp_d2[u], dp_sel[u], dp_clr[u]}, 0);
    chk($sformatf("%s_u%0d_rsp", tag, u), {rsp_v[u], rsp_id[u], rsp_data[u], rsp_ovf[u], rsp_tr[u]}, 0);
    chk($sformatf("%s_u%0d_busy", tag, u), 32'(busy[u]), 0);
  endtask

  // One clock: drive at negedge, observe 1ns later, retire handshakes at posedge.
  task automatic tick();
    int k;
    logic bub;
    logic fire [4];
    for (int u = 0; u < 2; u++) begin
      for (int r = 0; r < 2; r++) begin
        k = u*2 + r;
        bub = (bq[k].size() > 0) && (acc_cnt[k] == bub_after[k]) && (bub_len[k] > 0);
        if (bub) bub_len[k]--;
        if (bq[k].size() > 0 && !bub) begin
          req_valid[u][r] = 1'b1;
          req_last[u][r]  = bq[k][0].last;
          d1[u][r] = bq[k][0].d1; d2[u][r] = bq[k][0].d2; sel[u][r] = bq[k][0].sel;
        end else begin
          req_valid[u][r] = 1'b0;
          req_last[u][r]  = 1'($urandom);
          d1[u][r] = 3'($urandom); d2[u][r] = 3'($urandom); sel[u][r] = 2'($urandom);
        end
      end
      rsp_ready[u] = (rsp_hold[u] == 0);
    end
    #1;
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("u%0d_ready_onehot", u), 32'($onehot0(o_ready[u])), 1);
      if (dp_clr[u]) clr_cnt[u]++;
      if (rsp_v[u] && !prev_v[u]) first_rsp_cyc[u] = cyc;
      for (int r = 0; r < 2; r++) fire[u*2+r] = req_valid[u][r] && o_ready[u][r];
      if (rsp_v[u]) begin
        k = u*2 + int'(rsp_id[u]);
        chk($sformatf("u%0d_rsp_expected", u), 32'(eq[k].size() > 0), 1);
        if (eq[k].size() > 0) begin
          chk($sformatf("u%0d_rsp_data", u), 32'(rsp_data[u]), eq[k][0].data);
          chk($sformatf("u%0d_rsp_ovf", u), 32'(rsp_ovf[u]), eq[k][0].ovf);
          chk($sformatf("u%0d_rsp_trunc", u), 32'(rsp_tr[u]), eq[k][0].trunc);
          if (rsp_ready[u]) void'(eq[k].pop_front());
        end
        if (rsp_ready[u]) begin
          chk($sformatf("u%0d_clear_pulses", u), clr_cnt[u], 1);
          clr_cnt[u] = 0;
          lastr[u].id = int'(rsp_id[u]); lastr[u].data = int'(rsp_data[u]);
          lastr[u].ovf = int'(rsp_ovf[u]); lastr[u].trunc = int'(rsp_tr[u]);
          ord[u].push_back(int'(rsp_id[u]));
          nrsp[u]++;
        end else if (rsp_hold[u] > 0) begin
          rsp_hold[u]--;
        end
      end
      prev_v[u] = rsp_v[u] && !rsp_ready[u];
    end
    @(posedge clk);
    for (int j = 0; j < 4; j++) if (fire[j]) begin void'(bq[j].pop_front()); acc_cnt[j]++; end
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_until(int u, int n, int budget);
    while (nrsp[u] < n && budget > 0) begin tick(); budget--; end
    chk($sformatf("u%0d_responses_by_deadline", u), nrsp[u], n);
  endtask

  initial begin
    int c0, len, base, rr;
    nvec = 0; nerr = 0; cyc = 0;
    for (int k = 0; k < 4; k++) begin mcnt[k] = 0; msum[k] = 0; acc_cnt[k] = 0; bub_after[k] = -1; bub_len[k] = 0; end
    for (int u = 0; u < 2; u++) begin
      rsp_hold[u] = 0; nrsp[u] = 0; clr_cnt[u] = 0; first_rsp_cyc[u] = 0; prev_v[u] = 1'b0;
      req_valid[u] = '0; req_last[u] = '0; rsp_ready[u] = 1'b0;
      for (int r = 0; r < 2; r++) begin d1[u][r] = '0; d2[u][r] = '0; sel[u][r] = '0; end
    end
    rst_n = 1'b0;
    @(negedge clk);
    repeat (3) tick();
    reset_chk(0, "por");
    reset_chk(1, "por");
    rst_n = 1'b1;
    repeat (2) tick();

    // Basic job: 3+4 then 7+7 -> 21, response four cycles after the clear.
    push(0, 0, 2'd2, 3'd3, 3'd4, 1'b0);
    push(0, 0, 2'd2, 3'd7, 3'd7, 1'b1);
    c0 = cyc;
    run_until(0, 1, 50);
    chk("basic_latency", first_rsp_cyc[0] - c0, 5);
    chk("basic_id", lastr[0].id, 0);
    chk("basic_data", lastr[0].data, 21);
    chk("basic_ovf", lastr[0].ovf, 0);
    chk("basic_trunc", lastr[0].trunc, 0);

    // Overflow: 5 x 14 = 70 wraps to 6.
    for (int i = 0; i < 5; i++) push(0, 1, 2'd2, 3'd7, 3'd7, i == 4);
    run_until(0, 2, 60);
    chk("ovf_id", lastr[0].id, 1);
    chk("ovf_data", lastr[0].data, 6);
    chk("ovf_flag", lastr[0].ovf, 1);

    // Contention on the idle-since-reset instance: both queued together.
    for (int j = 0; j < 4; j++) begin
      rr  = j % 2;
      len = $urandom_range(1, 3);
      for (int i = 0; i < len; i++) push(1, rr, 2'($urandom), 3'($urandom), 3'($urandom), i == len-1);
    end
    run_until(1, 4, 200);
    for (int j = 0; j < 4; j++) chk($sformatf("rr_order%0d", j), (ord[1].size() > j) ? ord[1][j] : -1, j % 2);

    // Truncation at 4: six no-last beats of 1, then a closing beat.
    for (int i = 0; i < 6; i++) push(1, 0, 2'd0, 3'd1, 3'($urandom), 1'b0);
    push(1, 0, 2'd0, 3'd1, 3'd0, 1'b1);
    run_until(1, 5, 60);
    chk("trunc_data", lastr[1].data, 4);
    chk("trunc_flag", lastr[1].trunc, 1);
    run_until(1, 6, 60);
    chk("trunc_rest_data", lastr[1].data, 3);
    chk("trunc_rest_flag", lastr[1].trunc, 0);

    // Last beat exactly on the limit is not a truncation.
    for (int i = 0; i < 4; i++) push(1, 1, 2'd2, 3'($urandom), 3'($urandom), i == 3);
    run_until(1, 7, 60);
    chk("limit_last_id", lastr[1].id, 1);
    chk("limit_last_trunc", lastr[1].trunc, 0);

    // Bubbles (3 cycles after beat 2) and 5 cycles of response backpressure.
    for (int i = 0; i < 6; i++) push(0, 0, 2'($urandom), 3'($urandom), 3'($urandom), i == 5);
    bub_after[0] = acc_cnt[0] + 2;
    bub_len[0]   = 3;
    rsp_hold[0]  = 5;
    c0 = cyc;
    run_until(0, 3, 100);
    chk("bubble_latency", first_rsp_cyc[0] - c0, 12);
    chk("backpressure_consumed", rsp_hold[0], 0);

    // Reset while beat 2 of a job is on the bus.
    for (int i = 0; i < 4; i++) push(0, 0, 2'($urandom), 3'($urandom), 3'($urandom), i == 3);
    base = acc_cnt[0];
    len  = 40;
    while (acc_cnt[0] < base + 1 && len > 0) begin tick(); len--; end
    chk("mid_reset_reached_beat2", acc_cnt[0], base + 1);
    req_valid[0][0] = 1'b1;
    d1[0][0] = 3'd5; d2[0][0] = 3'd6; sel[0][0] = 2'd2;
    rst_n = 1'b0;
    #1;
    reset_chk(0, "midrst");
    reset_chk(1, "midrst");
    bq[0].delete(); eq[0].delete();
    mcnt[0] = 0; msum[0] = 0; clr_cnt[0] = 0; prev_v[0] = 1'b0;
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) push(0, 0, 2'($urandom), 3'($urandom), 3'($urandom), i == 2);
    run_until(0, 4, 60);
    chk("post_reset_id", lastr[0].id, 0);
    repeat (2) tick();

    chk("all_beats_consumed", bq[0].size() + bq[1].size() + bq[2].size() + bq[3].size(), 0);
    chk("all_responses_seen", eq[0].size() + eq[1].size() + eq[2].size() + eq[3].size(), 0);
    chk("idle_at_end", {busy[0], busy[1]}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
